alien_bomb_move: RTL and testbench

//  Downward counterpart of the player projectile: drops one bomb from a live alien column toward the player.

---
 rtl/alien_bomb_move_if.sv | 22 ++
 rtl/alien_bomb_move.sv | 114 +++++++++++
 tb/tb_alien_bomb_move.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alien_bomb_move_if.sv
// Bomb mover bus: frame/game controls and formation state in, bomb position and status out.
interface alien_bomb_move_if #(parameter int NUM_COLS = 8);
  logic                startOfFrame;
  logic                enable;
  logic [NUM_COLS-1:0] alive_cols;
  logic [10:0]         formation_x;
  logic [10:0]         formation_y;
  logic                collision;
  logic                active;
  logic                fired;
  logic [10:0]         bomb_x;
  logic [10:0]         bomb_y;

  modport master (
    output startOfFrame, enable, alive_cols, formation_x, formation_y, collision,
    input  active, fired, bomb_x, bomb_y
  );
  modport slave (
    input  startOfFrame, enable, alive_cols, formation_x, formation_y, collision,
    output active, fired, bomb_x, bomb_y
  );
endinterface

// File: rtl/alien_bomb_move.sv
// Single alien bomb: picks a live column via LFSR, drops the bomb a fixed step per frame,
// and retires it on collision or at the screen bottom.
module alien_bomb_move #(
  parameter int NUM_COLS         = 8,
  parameter int COL_PITCH        = 32,
  parameter int ALIEN_W          = 16,
  parameter int BOMB_W           = 4,
  parameter int ALIEN_BOTTOM_OFF = 16,
  parameter int SPEED            = 3,
  parameter int COOLDOWN_FRAMES  = 45,
  parameter int Y_BOTTOM         = 463
) (
  input  logic               clk,
  input  logic               reset,
  alien_bomb_move_if.slave   bus
);
  localparam int CW = $clog2(NUM_COLS);
  localparam int SW = CW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] MOVE   = 2'd2;

  localparam logic [15:0] CD_INIT = 16'(COOLDOWN_FRAMES);
  localparam logic [10:0] X_OFF   = 11'((ALIEN_W - BOMB_W) / 2);
  localparam logic [10:0] Y_OFF   = 11'(ALIEN_BOTTOM_OFF);
  localparam logic [10:0] PITCH   = 11'(COL_PITCH);
  localparam logic [16:0] STEP    = 17'(SPEED * 64);
  localparam logic [11:0] SPD12   = 12'(SPEED);
  localparam logic [11:0] YB12    = 12'(Y_BOTTOM);
  localparam logic [SW-1:0] SCAN_LAST = SW'(NUM_COLS - 1);

  logic [1:0]    state_q;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [15:0]   cooldown_q;
  logic [CW-1:0] col_q;
  logic [SW-1:0] scan_q;
  logic [10:0]   bomb_x_q;
  logic [16:0]   ypos_q;   // Y in 1/64 pixel units
  logic          active_q, fired_q, hit_q;
  logic          retire_bottom;

  // x^8+x^6+x^5+x^4+1, maximal length so the nonzero seed never reaches zero
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign retire_bottom = ({1'b0, ypos_q[16:6]} + SPD12) > YB12;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= 8'hA5;
      cooldown_q <= CD_INIT;
      col_q      <= '0;
      scan_q     <= '0;
      bomb_x_q   <= '0;
      ypos_q     <= '0;
      active_q   <= 1'b0;
      fired_q    <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      fired_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.startOfFrame && bus.enable) begin
            if (cooldown_q != 16'd0) begin
              cooldown_q <= cooldown_q - 16'd1;
            end else begin
              col_q   <= lfsr_q[CW-1:0];
              scan_q  <= '0;
              state_q <= SELECT;
            end
          end
        end
        SELECT: begin
          if (bus.alive_cols[col_q]) begin
            bomb_x_q <= bus.formation_x + 11'(col_q) * PITCH + X_OFF;
            ypos_q   <= {bus.formation_y + Y_OFF, 6'd0};
            active_q <= 1'b1;
            fired_q  <= 1'b1;
            hit_q    <= 1'b0;
            state_q  <= MOVE;
          end else begin
            col_q  <= col_q + 1'b1;
            scan_q <= scan_q + 1'b1;
            if (scan_q == SCAN_LAST) begin
              cooldown_q <= CD_INIT;
              state_q    <= IDLE;
            end
          end
        end
        MOVE: begin
          if (bus.startOfFrame) begin
            if (hit_q || bus.collision || (bus.enable && retire_bottom)) begin
              active_q   <= 1'b0;
              cooldown_q <= CD_INIT;
              state_q    <= IDLE;
            end else if (bus.enable) begin
              ypos_q <= ypos_q + STEP;
            end
          end else if (bus.collision) begin
            hit_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.active = active_q;
  assign bus.fired  = fired_q;
  assign bus.bomb_x = bomb_x_q;
  assign bus.bomb_y = ypos_q[16:6];
endmodule

// File: tb/tb_alien_bomb_move.sv
// Directed bench for alien_bomb_move: cooldown, launch geometry, motion, retire paths, reset.
module tb_alien_bomb_move;
  logic clk = 1'b0;
  logic reset;
  int npass = 0;
  int ntotal = 0;
  int fire_cnt = 0;
  int sel_cnt = 0;
  int f0, s0;
  logic ok;

  always #5 clk = ~clk;

  alien_bomb_move_if #(.NUM_COLS(8)) ifc();

  alien_bomb_move #(.COOLDOWN_FRAMES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always @(negedge clk) begin
    if (ifc.fired === 1'b1) fire_cnt++;
    if (dut.state_q === 2'd1) sel_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic sof(input logic coll);
    @(posedge clk); #1;
    ifc.startOfFrame = 1'b1;
    ifc.collision    = coll;
    @(posedge clk); #1;
    ifc.startOfFrame = 1'b0;
    ifc.collision    = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic sofs(input int n);
    for (int i = 0; i < n; i++) sof(1'b0);
  endtask

  task automatic coll_pulse();
    @(posedge clk); #1;
    ifc.collision = 1'b1;
    @(posedge clk); #1;
    ifc.collision = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    ifc.startOfFrame = 1'b0;
    ifc.enable       = 1'b1;
    ifc.alive_cols   = 8'hFF;
    ifc.formation_x  = 11'd100;
    ifc.formation_y  = 11'd50;
    ifc.collision    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", ifc.active, 0);
    check("rst_fired", ifc.fired, 0);
    check("rst_x", ifc.bomb_x, 0);
    check("rst_y", ifc.bomb_y, 0);
    reset = 1'b0;
    check("rst_cooldown", dut.cooldown_q, 4);

    // cooldown: frames 1-4 only count down
    f0 = fire_cnt;
    sofs(4);
    check("cd_nofire", fire_cnt - f0, 0);
    check("cd_inactive", ifc.active, 0);
    check("cd_zero", dut.cooldown_q, 0);
    sof(1'b0);
    check("cd_fire_once", fire_cnt - f0, 1);
    check("cd_active", ifc.active, 1);
    check("cd_launch_y", ifc.bomb_y, 66);
    ok = (ifc.bomb_x >= 106) && (ifc.bomb_x <= 330) && (((ifc.bomb_x - 106) % 32) == 0);
    check("cd_x_on_grid", ok, 1);

    // mid-frame collision retires at the next frame
    coll_pulse();
    check("hit_still_active", ifc.active, 1);
    sof(1'b0);
    check("hit_retire", ifc.active, 0);
    check("hit_y_held", ifc.bomb_y, 66);

    // only column 3 alive
    ifc.alive_cols = 8'b0000_1000;
    f0 = fire_cnt;
    sofs(5);
    check("c3_fired", fire_cnt - f0, 1);
    check("c3_x", ifc.bomb_x, 202);
    check("c3_y", ifc.bomb_y, 66);
    sofs(10);
    check("c3_y_10", ifc.bomb_y, 96);
    ifc.alive_cols = 8'h00;
    sofs(8);
    check("c3_y_120", ifc.bomb_y, 120);
    check("c3_alive_change", ifc.active, 1);
    coll_pulse();
    sof(1'b0);
    check("c3_retire", ifc.active, 0);
    check("c3_y_held", ifc.bomb_y, 120);
    check("c3_idle", dut.state_q, 0);
    check("c3_cd_reload", dut.cooldown_q, 4);
    check("c3_x_held", ifc.bomb_x, 202);

    // enable low in IDLE freezes cooldown
    ifc.enable = 1'b0;
    sof(1'b0);
    check("freeze_cd", dut.cooldown_q, 4);
    ifc.enable = 1'b1;
    ifc.alive_cols = 8'b0000_1000;
    ifc.formation_y = 11'd434;
    sofs(5);
    check("bot_launch", ifc.bomb_y, 450);
    sof(1'b0); check("bot_453", ifc.bomb_y, 453);
    sof(1'b0); check("bot_456", ifc.bomb_y, 456);
    sof(1'b0); check("bot_459", ifc.bomb_y, 459);
    sof(1'b0); check("bot_462", ifc.bomb_y, 462);
    ifc.enable = 1'b0;
    sof(1'b0);
    check("frz_y", ifc.bomb_y, 462);
    check("frz_active", ifc.active, 1);
    ifc.enable = 1'b1;
    sof(1'b0);
    check("bot_retire", ifc.active, 0);
    check("bot_y_held", ifc.bomb_y, 462);

    // collision coincident with startOfFrame: no move, retire
    ifc.formation_y = 11'd50;
    sofs(5);
    check("sc_launch", ifc.bomb_y, 66);
    sof(1'b1);
    check("sc_retire", ifc.active, 0);
    check("sc_y", ifc.bomb_y, 66);

    // no live column: full scan, no fire
    ifc.alive_cols = 8'h00;
    sofs(4);
    f0 = fire_cnt;
    s0 = sel_cnt;
    sof(1'b0);
    check("empty_scan_len", sel_cnt - s0, 8);
    check("empty_nofire", fire_cnt - f0, 0);
    check("empty_cd", dut.cooldown_q, 4);
    check("empty_idle", dut.state_q, 0);

    // reset while in flight
    ifc.alive_cols = 8'b0000_1000;
    sofs(5);
    sof(1'b0);
    check("rm_y", ifc.bomb_y, 69);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rm_active", ifc.active, 0);
    check("rm_fired", ifc.fired, 0);
    check("rm_x", ifc.bomb_x, 0);
    check("rm_y0", ifc.bomb_y, 0);
    check("rm_idle", dut.state_q, 0);
    check("rm_cd", dut.cooldown_q, 4);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
